// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: encodings, ALU ops and the ID/EX bundle.
// Imported by the decode and execute stages.
package cpu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011
    } alu_op_t;

    // Control half of ID/EX; operand data is carried alongside at XLEN.
    typedef struct packed {
        logic        ex_valid;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src;
        alu_op_t     alu_op;
        logic [4:0]  dest_reg;
        logic [15:0] imm;
    } id_ex_t;

    localparam id_ex_t ID_EX_BUBBLE = id_ex_t'(0);

endpackage

// File: rtl/reg_file.sv
// 2R1W register file, r0 hardwired to zero.
// Same-cycle writes bypass straight to the read ports.
module reg_file #(
    parameter  int NREGS = 32,
    parameter  int XLEN  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [AW-1:0]   ra1_i,
    input  logic [AW-1:0]   ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [AW-1:0]   wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    // Storage: cleared on reset, writes to r0 dropped
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    // Read ports: r0 reads zero, otherwise writeback value wins
    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (ra1_i == '0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
        if (ra2_i == '0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/id_stage.sv
// Decode stage: decoder, load-use hazard unit and ID/EX register.
// Operands come from the local register file written by writeback.
module id_stage
    import cpu_pkg::*;
#(
    parameter  int NREGS = 32,
    parameter  int XLEN  = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic            instr_valid,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            id_stall,
    output logic [XLEN-1:0] reg1_data,
    output logic [XLEN-1:0] reg2_data,
    output logic [15:0]     imm,
    output logic            alu_src,
    output logic [2:0]      alu_op,
    output logic [4:0]      dest_reg,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ex_valid,
    output logic            illegal
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic            is_r;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;

    id_ex_t          dec;
    logic            dec_ok;
    logic            reads_rt;
    logic            hazard;
    logic            accept;

    id_ex_t          ex_d;
    id_ex_t          ex_q;
    logic [XLEN-1:0] r1_d;
    logic [XLEN-1:0] r1_q;
    logic [XLEN-1:0] r2_d;
    logic [XLEN-1:0] r2_q;
    logic            ill_d;
    logic            ill_q;

    assign opcode = instr[31:26];
    assign rs     = instr[25:21];
    assign rt     = instr[20:16];
    assign rd     = instr[15:11];
    assign funct  = instr[5:0];
    assign is_r   = (opcode == OP_RTYPE);

    reg_file #(
        .NREGS (NREGS),
        .XLEN  (XLEN)
    ) u_rf (
        .clk_i  (clk),
        .rst_ni (reset),
        .ra1_i  (AW'(rs)),
        .ra2_i  (AW'(rt)),
        .rd1_o  (rs_val),
        .rd2_o  (rt_val),
        .we_i   (wb_we),
        .wa_i   (wb_addr),
        .wd_i   (wb_data)
    );

    // Decoder: control bundle for the current instruction word
    always_comb begin
        dec          = ID_EX_BUBBLE;
        dec.ex_valid = 1'b1;
        dec.imm      = instr[15:0];
        dec_ok       = 1'b1;
        reads_rt     = 1'b0;
        unique case (1'b1)
            (is_r && (funct == FN_ADD)): begin
                dec.alu_op    = ALU_ADD;
                dec.dest_reg  = rd;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
            end
            (is_r && (funct == FN_SUB)): begin
                dec.alu_op    = ALU_SUB;
                dec.dest_reg  = rd;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
            end
            (is_r && (funct == FN_AND)): begin
                dec.alu_op    = ALU_AND;
                dec.dest_reg  = rd;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
            end
            (is_r && (funct == FN_OR)): begin
                dec.alu_op    = ALU_OR;
                dec.dest_reg  = rd;
                dec.reg_write = 1'b1;
                reads_rt      = 1'b1;
            end
            (opcode == OP_ADDI): begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.dest_reg  = rt;
                dec.reg_write = 1'b1;
            end
            (opcode == OP_ANDI): begin
                dec.alu_op    = ALU_AND;
                dec.alu_src   = 1'b1;
                dec.dest_reg  = rt;
                dec.reg_write = 1'b1;
            end
            (opcode == OP_ORI): begin
                dec.alu_op    = ALU_OR;
                dec.alu_src   = 1'b1;
                dec.dest_reg  = rt;
                dec.reg_write = 1'b1;
            end
            (opcode == OP_LW): begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.dest_reg  = rt;
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
            end
            (opcode == OP_SW): begin
                dec.alu_op    = ALU_ADD;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                reads_rt      = 1'b1;
            end
            default: begin
                dec    = ID_EX_BUBBLE;
                dec_ok = 1'b0;
            end
        endcase
    end

    assign hazard = ex_q.ex_valid && ex_q.mem_read &&
                    (ex_q.dest_reg != '0) && instr_valid &&
                    ((ex_q.dest_reg == rs) ||
                     (reads_rt && (ex_q.dest_reg == rt)));

    assign id_stall = hazard && !flush;
    assign accept   = instr_valid && !flush && !hazard;

    // ID/EX next state: bubble unless a real instruction is accepted
    always_comb begin
        ex_d  = ID_EX_BUBBLE;
        r1_d  = '0;
        r2_d  = '0;
        ill_d = 1'b0;
        if (accept) begin
            if (dec_ok) begin
                ex_d = dec;
                r1_d = rs_val;
                r2_d = rt_val;
            end else begin
                ill_d = 1'b1;
            end
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_q  <= ID_EX_BUBBLE;
            r1_q  <= '0;
            r2_q  <= '0;
            ill_q <= 1'b0;
        end else begin
            ex_q  <= ex_d;
            r1_q  <= r1_d;
            r2_q  <= r2_d;
            ill_q <= ill_d;
        end
    end

    assign reg1_data = r1_q;
    assign reg2_data = r2_q;
    assign imm       = ex_q.imm;
    assign alu_src   = ex_q.alu_src;
    assign alu_op    = ex_q.alu_op;
    assign dest_reg  = ex_q.dest_reg;
    assign reg_write = ex_q.reg_write;
    assign mem_read  = ex_q.mem_read;
    assign mem_write = ex_q.mem_write;
    assign ex_valid  = ex_q.ex_valid;
    assign illegal   = ill_q;

endmodule
